sqr6_rr_scheduler: RTL and testbench

Shares one combinational 6-bit squarer (`sqr6_core`, y = x·x, 12-bit result) between NREQ requesters. A round-robin arbiter selects the requester; an operand register feeds the squarer and a result register captures its output. Both stages use valid/ready backpressure, and each response is tagged with the requester ID. The block sits between operand producers and a single consumer of squared values.

---
 rtl/sqr6_pkg.sv | 17 +
 rtl/sqr6_core.sv | 20 ++
 rtl/sqr6_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_sqr6_rr_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqr6_pkg.sv
// ----------------------------------------------------------------------------
// sqr6_pkg
// Shared types and widths for the shared 6-bit squarer and its scheduler.
//   OPW   : operand width (6 bits, unsigned)
//   RESW  : result width (12 bits, enough for 63*63 = 3969)
//   op_t  : operand type
//   res_t : result type
// ----------------------------------------------------------------------------
package sqr6_pkg;

   localparam int OPW  = 6;
   localparam int RESW = 12;

   typedef logic [OPW-1:0]  op_t;
   typedef logic [RESW-1:0] res_t;

endpackage

// File: rtl/sqr6_core.sv
// ----------------------------------------------------------------------------
// sqr6_core
// Purely combinational squarer, y = x * x. Behavioural model; interchangeable
// with the existing gate-level squarer netlist.
// Ports:
//   i_x : operand (op_t)
//   o_y : square of the operand (res_t)
// ----------------------------------------------------------------------------
module sqr6_core
   import sqr6_pkg::*;
(
   input  op_t  i_x,
   output res_t o_y
);

   // Both factors are widened to the result width first so the product is
   // computed at full 12-bit precision.
   assign o_y = res_t'(i_x) * res_t'(i_x);

endmodule

// File: rtl/sqr6_rr_scheduler.sv
// ----------------------------------------------------------------------------
// sqr6_rr_scheduler
// Shares one sqr6_core between NREQ requesters. A round-robin arbiter picks a
// requester, its operand lands in stage A, the squarer sits between stage A
// and stage B, and stage B presents the tagged result to a single consumer.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_data   : packed operands, requester i in bits [6i+5:6i]
//   req_ready  : one-hot (or zero) accept strobe
//   rsp_valid  : stage B holds a result
//   rsp_data   : squared operand
//   rsp_id     : requester that supplied the operand
//   rsp_ready  : consumer takes the result this cycle
//   busy       : either pipeline stage is occupied
// ----------------------------------------------------------------------------
module sqr6_rr_scheduler
   import sqr6_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [OPW*NREQ-1:0] req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic                rsp_valid,
   output res_t                rsp_data,
   output logic [IDW-1:0]      rsp_id,
   input  logic                rsp_ready,
   output logic                busy
);

   logic           r_aValid;
   op_t            r_aData;
   logic [IDW-1:0] r_aId;
   logic           r_bValid;
   res_t           r_bData;
   logic [IDW-1:0] r_bId;
   logic [IDW-1:0] r_ptr;

   logic [NREQ-1:0] w_rotValid;
   logic [IDW-1:0]  w_offset;
   logic [IDW-1:0]  w_grantIdx;
   logic            w_anyValid;
   logic            w_aAdv;
   logic            w_aCanAccept;
   logic            w_accept;
   res_t            w_square;

   // Round-robin arbiter: rotate the valid vector so the pointer position
   // becomes bit 0, pick the lowest set bit, then add the pointer back. NREQ is
   // a power of two, so the IDW-bit additions wrap modulo NREQ for free.
   always_comb begin
      w_rotValid = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_rotValid[k] = req_valid[r_ptr + IDW'(k)];
      end
      w_offset = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rotValid[k]) begin
            w_offset = IDW'(k);
         end
      end
      w_grantIdx = r_ptr + w_offset;
   end

   assign w_anyValid   = |req_valid;
   assign w_aAdv       = r_aValid & (~r_bValid | rsp_ready);
   assign w_aCanAccept = ~r_aValid | w_aAdv;

   // Ready is a pure function of valids, rsp_ready and state; it is held low
   // while reset is asserted so nothing handshakes into a clearing pipeline.
   always_comb begin
      req_ready = '0;
      if (!rst && w_anyValid && w_aCanAccept) begin
         req_ready[w_grantIdx] = 1'b1;
      end
   end

   assign w_accept = |req_ready;

   // Stage A plus the priority pointer. A new accept always wins over simply
   // emptying, because an accept implies A either was empty or is advancing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aValid <= 1'b0;
         r_aData  <= '0;
         r_aId    <= '0;
         r_ptr    <= '0;
      end else if (w_accept) begin
         r_aValid <= 1'b1;
         r_aData  <= req_data[int'(w_grantIdx) * OPW +: OPW];
         r_aId    <= w_grantIdx;
         r_ptr    <= w_grantIdx + IDW'(1);
      end else if (w_aAdv) begin
         r_aValid <= 1'b0;
      end
   end

   sqr6_core u_core (
      .i_x (r_aData),
      .o_y (w_square)
   );

   // Stage B captures the square whenever A advances; otherwise it empties
   // once the consumer takes the result, and holds steady while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bValid <= 1'b0;
         r_bData  <= '0;
         r_bId    <= '0;
      end else if (w_aAdv) begin
         r_bValid <= 1'b1;
         r_bData  <= w_square;
         r_bId    <= r_aId;
      end else if (rsp_ready) begin
         r_bValid <= 1'b0;
      end
   end

   assign rsp_valid = r_bValid;
   assign rsp_data  = r_bData;
   assign rsp_id    = r_bId;
   assign busy      = r_aValid | r_bValid;

endmodule

// File: tb/tb_sqr6_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sqr6_rr_scheduler
// Self-checking bench for sqr6_rr_scheduler with NREQ = 4. Accepted operands
// push their expected square and ID into a queue; delivered results pop it.
// ----------------------------------------------------------------------------
module tb_sqr6_rr_scheduler;

   localparam int NREQ = 4;

   typedef struct {
      logic [1:0]  id;
      logic [11:0] data;
   } expItem_t;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [23:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [11:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic        busy;

   expItem_t    scoreboard[$];
   int          vectorCount;
   int          miscompareCount;
   int          inCount;
   int          outCount;
   logic        prevStall;
   logic [11:0] heldData;
   logic [1:0]  heldId;

   sqr6_rr_scheduler #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Runs at each falling edge: pops/compares delivered results, checks that a
   // stalled result stays put, and pushes the expectation for every accept.
   task automatic updateScoreboard();
      expItem_t item;
      if (rst) begin
         scoreboard.delete();
         prevStall = 1'b0;
         inCount   = 0;
         outCount  = 0;
      end else begin
         if (prevStall) begin
            checkOutput("holdValid", 32'(rsp_valid), 32'd1);
            checkOutput("holdData", 32'(rsp_data), 32'(heldData));
            checkOutput("holdId", 32'(rsp_id), 32'(heldId));
         end
         if (rsp_valid && rsp_ready) begin
            outCount++;
            if (scoreboard.size() == 0) begin
               checkOutput("sbUnderflow", 32'(scoreboard.size()), 32'd1);
            end else begin
               item = scoreboard.pop_front();
               checkOutput("rspData", 32'(rsp_data), 32'(item.data));
               checkOutput("rspId", 32'(rsp_id), 32'(item.id));
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               item.id   = 2'(i);
               item.data = 12'(req_data[i*6 +: 6]) * 12'(req_data[i*6 +: 6]);
               scoreboard.push_back(item);
               inCount++;
            end
         end
         prevStall = rsp_valid & ~rsp_ready;
         heldData  = rsp_data;
         heldId    = rsp_id;
      end
   endtask

   // Drive this cycle's inputs (called just after a rising edge) and advance to
   // the falling edge where outputs are sampled.
   task automatic applyStimulus(input logic [3:0] valid, input logic ready);
      req_valid = valid;
      rsp_ready = ready;
      @(negedge clk);
      updateScoreboard();
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic setData(input int idx, input logic [5:0] value);
      req_data[idx*6 +: 6] = value;
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus(4'b0000, 1'b1);
         nextCycle();
      end
   endtask

   initial begin
      logic [1:0] requester;
      logic       accepted;
      int         waited;

      vectorCount     = 0;
      miscompareCount = 0;
      inCount         = 0;
      outCount        = 0;
      prevStall       = 1'b0;
      heldData        = '0;
      heldId          = '0;
      rst             = 1'b1;
      req_valid       = 4'b1111;
      req_data        = '0;
      rsp_ready       = 1'b0;

      // Reset state, including ready held low despite valids.
      @(negedge clk);
      updateScoreboard();
      checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
      checkOutput("rstRspData", 32'(rsp_data), 32'd0);
      checkOutput("rstRspId", 32'(rsp_id), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstReqReady", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single request: requester 1 sends 63.
      setData(1, 6'd63);
      applyStimulus(4'b0010, 1'b1);
      checkOutput("singleReady", 32'(req_ready), 32'b0010);
      nextCycle();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("singleC1Valid", 32'(rsp_valid), 32'd0);
      checkOutput("singleC1Busy", 32'(busy), 32'd1);
      nextCycle();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("singleC2Valid", 32'(rsp_valid), 32'd1);
      checkOutput("singleC2Data", 32'(rsp_data), 32'd3969);
      checkOutput("singleC2Id", 32'(rsp_id), 32'd1);
      nextCycle();

      // Pointer now at 2: with 0 and 2 valid, 2 wins, then 0.
      setData(0, 6'd11);
      setData(2, 6'd12);
      applyStimulus(4'b0101, 1'b1);
      checkOutput("ptr2First", 32'(req_ready), 32'b0100);
      nextCycle();
      applyStimulus(4'b0001, 1'b1);
      checkOutput("ptr2Second", 32'(req_ready), 32'b0001);
      nextCycle();
      drain(4);

      // Saturation: pointer is 1, so grants run 1,2,3,0,1,2,3,0.
      for (int i = 0; i < 4; i++) setData(i, 6'(i));
      for (int k = 0; k < 8; k++) begin
         applyStimulus(4'b1111, 1'b1);
         checkOutput("satGrant", 32'(req_ready), 32'(4'b0001 << ((1 + k) % 4)));
         nextCycle();
      end
      drain(4);

      // Backpressure: pointer is 1. Accept 1 (5) then 2 (7) with rsp_ready low.
      setData(1, 6'd5);
      setData(2, 6'd7);
      setData(3, 6'd10);
      applyStimulus(4'b0110, 1'b0);
      checkOutput("bpAccept1", 32'(req_ready), 32'b0010);
      nextCycle();
      applyStimulus(4'b0100, 1'b0);
      checkOutput("bpAccept2", 32'(req_ready), 32'b0100);
      nextCycle();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(4'b1000, 1'b0);
         checkOutput("bpStallReady", 32'(req_ready), 32'd0);
         checkOutput("bpStallData", 32'(rsp_data), 32'd25);
         checkOutput("bpStallBusy", 32'(busy), 32'd1);
         nextCycle();
      end
      applyStimulus(4'b1000, 1'b1);
      checkOutput("bpReleaseReady", 32'(req_ready), 32'b1000);
      checkOutput("bpReleaseData", 32'(rsp_data), 32'd25);
      nextCycle();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("bpSecondData", 32'(rsp_data), 32'd49);
      checkOutput("bpSecondId", 32'(rsp_id), 32'd2);
      nextCycle();
      applyStimulus(4'b0000, 1'b1);
      checkOutput("bpThirdData", 32'(rsp_data), 32'd100);
      nextCycle();
      drain(3);

      // Priority rotation: pointer is 0; accepting 2 moves it to 3.
      setData(2, 6'd20);
      setData(3, 6'd30);
      setData(0, 6'd40);
      applyStimulus(4'b0100, 1'b1);
      checkOutput("rotSetup", 32'(req_ready), 32'b0100);
      nextCycle();
      applyStimulus(4'b1100, 1'b1);
      checkOutput("rotFirst", 32'(req_ready), 32'b1000);
      nextCycle();
      applyStimulus(4'b0100, 1'b1);
      checkOutput("rotSecond", 32'(req_ready), 32'b0100);
      nextCycle();
      applyStimulus(4'b1001, 1'b1);
      checkOutput("rotPtr3", 32'(req_ready), 32'b1000);
      nextCycle();
      drain(4);

      // Reset mid-flight: pointer is 0; fill both stages, then reset.
      setData(0, 6'd3);
      setData(1, 6'd4);
      setData(2, 6'd9);
      applyStimulus(4'b0111, 1'b0);
      checkOutput("rmfAccept0", 32'(req_ready), 32'b0001);
      nextCycle();
      applyStimulus(4'b0110, 1'b0);
      checkOutput("rmfAccept1", 32'(req_ready), 32'b0010);
      nextCycle();
      applyStimulus(4'b0100, 1'b0);
      checkOutput("rmfFullReady", 32'(req_ready), 32'd0);
      checkOutput("rmfFullValid", 32'(rsp_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rmfAsyncValid", 32'(rsp_valid), 32'd0);
      checkOutput("rmfAsyncBusy", 32'(busy), 32'd0);
      checkOutput("rmfAsyncReady", 32'(req_ready), 32'd0);
      @(negedge clk);
      updateScoreboard();
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(4'b0110, 1'b1);
      checkOutput("rmfFirstAfter", 32'(req_ready), 32'b0010);
      nextCycle();
      applyStimulus(4'b0100, 1'b1);
      checkOutput("rmfSecondAfter", 32'(req_ready), 32'b0100);
      nextCycle();
      drain(4);

      // All 64 operands from random requesters under random rsp_ready.
      for (int op = 0; op < 64; op++) begin
         requester = 2'($urandom_range(0, 3));
         setData(int'(requester), 6'(op));
         waited   = 0;
         accepted = 1'b0;
         while (!accepted && waited < 100) begin
            applyStimulus(4'b0001 << requester, 1'($urandom_range(0, 1)));
            accepted = req_ready[requester];
            waited++;
            nextCycle();
         end
         if (!accepted) begin
            checkOutput("acceptTimeout", 32'(accepted), 32'd1);
         end
      end
      drain(6);
      checkOutput("countInOut", 32'(outCount), 32'(inCount));
      checkOutput("sbEmpty", 32'(scoreboard.size()), 32'd0);
      checkOutput("finalBusy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
